serial_addsub_unit: RTL

Parametrised multi-bit serial adder/subtractor, successor to the single-bit serial adder. Accepts two WIDTH-bit operands in parallel with a start strobe, processes them LSB-first DIGIT bits per clock through one carry flip-flop, and returns the parallel result with carry, signed overflow and a per-digit serial output stream. Used as an area-cheap arithmetic unit in datapaths where latency is acceptable.

---
 rtl/serial_addsub_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_addsub_unit.sv
// Multi-bit serial adder/subtractor.
// Operands are loaded in parallel on an accepted start and then processed
// LSB-first, DIGIT bits per clock, through a single carry flop. The result is
// returned in parallel together with the final carry, the signed overflow flag
// and a per-digit serial output stream.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf,
  output logic [DIGIT-1:0] sum_digit,
  output logic             sum_valid
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One digit slice of the ripple: DIGIT-bit add with carry-in, carry in the MSB.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT-1:0] sdig_q, sdig_d;
  logic             sval_q, sval_d;

  logic [DIGIT:0]   dsum_s;
  logic [WIDTH-1:0] res_next_s;

  // Next-state and next-output computation for the load / run / done sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sdig_d  = sdig_q;
    sval_d  = 1'b0;

    dsum_s     = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    // New digit enters at the MSB end so the word is aligned after STEPS shifts.
    res_next_s = (res_q >> DIGIT) | (WIDTH'(dsum_s[DIGIT-1:0]) << (WIDTH - DIGIT));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + ~cin, i.e. a - b - cin.
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          amsb_d  = a_in[WIDTH-1];
          bmsb_d  = sub ? ~b_in[WIDTH-1] : b_in[WIDTH-1];
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum_s[DIGIT];
        res_d   = res_next_s;
        sdig_d  = dsum_s[DIGIT-1:0];
        sval_d  = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_next_s;
          cout_d  = dsum_s[DIGIT];
          ovf_d   = (amsb_q == bmsb_q) && (res_next_s[WIDTH-1] != amsb_q);
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sdig_q  <= '0;
      sval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sdig_q  <= sdig_d;
      sval_q  <= sval_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_out   = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign sum_digit = sdig_q;
  assign sum_valid = sval_q;

endmodule
